// File: rtl/rom_port_arb.sv
// rom_port_arb
// Arbiter and sequencer for the shared instruction-ROM port. Master 0 is the
// IFU fetch path, master 1 is the LSU constant-read path. One master is
// granted at a time (round-robin on ties), its address is registered and
// presented to the ROM until accepted, and the single returned word is routed
// back to the owner. Exactly one transaction is outstanding at any time.
//
// Optional feature macro: ROM_ARB_TIMEOUT_EN
//   When defined, a response watchdog counts cycles spent waiting for the ROM
//   and, after TIMEOUT_CYC cycles, completes the transaction with data 0 and a
//   timeout_err_o pulse. When undefined, the wait is unbounded and
//   timeout_err_o is tied low.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m0_req_valid_i/addr_i       fetch request
//   m0_req_ready_o              fetch request accepted this cycle
//   m0_rsp_valid_o/data_o       fetch response (1-cycle pulse)
//   m1_*                        same set for the LSU
//   rom_req_valid_o/addr_o      request to the ROM
//   rom_req_ready_i             ROM accepted the request
//   rom_rsp_valid_i/data_i      ROM response
//   timeout_err_o               watchdog fired (1-cycle pulse)
module rom_port_arb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_valid_i,
  input  logic [AW-1:0] m0_req_addr_i,
  output logic          m0_req_ready_o,
  output logic          m0_rsp_valid_o,
  output logic [DW-1:0] m0_rsp_data_o,
  input  logic          m1_req_valid_i,
  input  logic [AW-1:0] m1_req_addr_i,
  output logic          m1_req_ready_o,
  output logic          m1_rsp_valid_o,
  output logic [DW-1:0] m1_rsp_data_o,
  output logic          rom_req_valid_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic          rom_req_ready_i,
  input  logic          rom_rsp_valid_i,
  input  logic [DW-1:0] rom_rsp_data_i,
  output logic          timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic grant_vld;
  logic grant_sel;
  logic rsp_done;
  logic timeout_fire;

  // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
  always_comb begin
    grant_vld = (state_q == IDLE) && (m0_req_valid_i || m1_req_valid_i);
    grant_sel = (m0_req_valid_i && m1_req_valid_i) ? rr_ptr_q : m1_req_valid_i;
    rsp_done  = (state_q == RSP) && rom_rsp_valid_i;
  end

`ifdef ROM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter is zero in the first RSP cycle because it is held clear in
  // every other state; a genuine response in the limit cycle takes priority.
  always_comb begin
    cnt_d        = (state_q == RSP) ? cnt_q + 1'b1 : '0;
    timeout_fire = (state_q == RSP) && !rom_rsp_valid_i &&
                   (cnt_q == CW'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    timeout_fire = 1'b0;
  end
`endif

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic. A grant flips the preference away from the winner.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = REQ;
          owner_d  = grant_sel;
          rr_ptr_d = ~grant_sel;
          addr_d   = grant_sel ? m1_req_addr_i : m0_req_addr_i;
        end
      end
      REQ: begin
        if (rom_req_ready_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_done || timeout_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Response data is broadcast to both masters and qualified
  // only by the owner's valid; a watchdog completion returns zero.
  always_comb begin
    m0_req_ready_o  = grant_vld && !grant_sel;
    m1_req_ready_o  = grant_vld && grant_sel;
    rom_req_valid_o = (state_q == REQ);
    rom_addr_o      = addr_q;
    m0_rsp_valid_o  = (rsp_done || timeout_fire) && !owner_q;
    m1_rsp_valid_o  = (rsp_done || timeout_fire) && owner_q;
    m0_rsp_data_o   = timeout_fire ? '0 : rom_rsp_data_i;
    m1_rsp_data_o   = timeout_fire ? '0 : rom_rsp_data_i;
    timeout_err_o   = timeout_fire;
  end

endmodule

// File: doc/rom_port_arb.md
# rom_port_arb

Two-master arbiter and sequencer for the single instruction-ROM port. The IFU fetch path (master 0) and the LSU read-only path for ROM constants (master 1) share this port. The block grants one master at a time and drives the ROM request handshake. It routes the returned word back to the owner, with exactly one transaction outstanding. It sits between the IFU/LSU and the ROM bus interface.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYC, 64, response watchdog limit in cycles (used only with ROM_ARB_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_req_valid_i  in  1  fetch request valid
- m0_req_addr_i  in  AW  fetch address
- m0_req_ready_o  out  1  fetch request accepted this cycle
- m0_rsp_valid_o  out  1  fetch data valid (1-cycle pulse)
- m0_rsp_data_o  out  DW  fetch data
- m1_req_valid_i, m1_req_addr_i, m1_req_ready_o, m1_rsp_valid_o, m1_rsp_data_o: same as m0, for the LSU
- rom_req_valid_o  out  1  ROM request valid
- rom_addr_o  out  AW  ROM address
- rom_req_ready_i  in  1  ROM accepts request
- rom_rsp_valid_i  in  1  ROM data valid
- rom_rsp_data_i  in  DW  ROM data
- timeout_err_o  out  1  watchdog fired (1-cycle pulse); tied 0 without ROM_ARB_TIMEOUT_EN

## Operation
- Registered state: state ∈ {IDLE, REQ, RSP}, owner (1 bit), rr_ptr (1 bit, the preferred master), addr_q (AW).
- IDLE: if any mN_req_valid_i is asserted, grant one master:
  - only one valid: grant it;
  - both valid: grant rr_ptr.
- On grant:
  - mN_req_ready_o=1 combinationally for the granted master only;
  - addr_q<=its address; owner<=N; rr_ptr<=~N; go to REQ.
- Requests are never accepted outside IDLE; both req_ready_o are 0 in REQ and RSP.
- REQ: rom_req_valid_o=1 and rom_addr_o=addr_q. When rom_req_ready_i=1, go to RSP.
  - The address is held stable until accepted.
- RSP: on rom_rsp_valid_i=1:
  - m[owner]_rsp_valid_o=1 and m[owner]_rsp_data_o=rom_rsp_data_i, combinationally;
  - go to IDLE.
- rom_rsp_valid_i outside RSP is ignored. No response reaches either master.
- The non-owner rsp_valid_o is always 0. rsp_data_o of both masters carries rom_rsp_data_i; it is qualified only by valid.
- rr_ptr resets to 0, so master 0 wins the first tie.

## Timing
- Reset values: state=IDLE, owner=0, rr_ptr=0, addr_q=0. rom_req_valid_o=0, rom_addr_o=0, all req_ready_o=0, all rsp_valid_o=0, timeout_err_o=0.
- Cycle 0: grant/accept (req_ready pulse).
- Cycle 1: rom_req_valid_o first high.
- With an always-ready ROM that has 1-cycle response latency, rsp_valid appears in cycle 2.
- The next grant can happen in cycle 3, so peak throughput is 1 transaction per 3 cycles.
- rom_rsp_valid_i in the same cycle as rom_req_ready_i is ignored; the response must arrive in RSP.
- Reset mid-transaction aborts it immediately: no rsp pulse, and the request is lost. The master must re-issue after reset.
- A master may drop req_valid before being granted. No grant occurs for a dropped request.

## Configuration
- ROM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to RSP and increments each cycle spent in RSP.
  - When the counter reaches TIMEOUT_CYC without rom_rsp_valid_i, the block pulses m[owner]_rsp_valid_o with data 0 and pulses timeout_err_o in the same cycle. State then returns to IDLE.
  - A late ROM response after a timeout is ignored.
- ROM_ARB_TIMEOUT_EN undefined: no counter exists, RSP waits indefinitely, and timeout_err_o=0.

## Test plan
- Reset, then m0 only requests addr 0x0000_0010; ROM is ready and returns 0x0000_0013 one cycle later. Expect m0_req_ready in cycle 0, rom_addr_o=0x10 in cycle 1, m0_rsp_valid with 0x13 in cycle 2, and m1_rsp_valid never asserted.
- Both masters request continuously (m0 addr 0x100, m1 addr 0x200). Grants must alternate m0, m1, m0, m1, and rom_addr_o must alternate 0x100/0x200.
- ROM holds rom_req_ready_i=0 for 5 cycles. rom_req_valid_o and rom_addr_o stay stable for all 5 cycles, and no new grant occurs.
- A spurious rom_rsp_valid_i in IDLE produces no rsp_valid on either master.
- Assert rst_n low while in RSP. All outputs return to reset values asynchronously, and a later ROM response is ignored.
- With ROM_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=64, a ROM that never responds yields owner rsp_valid with data 0 and a timeout_err_o pulse 64 cycles after entering RSP. State returns to IDLE and the next request is granted.
